// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and defaults for the async-FIFO write-port arbiter.
//   arb_state_e    : arbiter FSM encoding (IDLE = arbitration bubble, BURST = grant held)
//   BURST_MAX_DEF  : default maximum accepted beats per grant
//   CNT_W_DEF      : default width of the accepted-beat counter
//   wrap_inc       : index + 1 with explicit wrap at n-1 -> 0 (n need not be a power of two)
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

    localparam int BURST_MAX_DEF = 4;
    localparam int CNT_W_DEF     = 16;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational rotating-priority encoder. Returns the first asserted request
// found when scanning ptr, ptr+1, ... (mod NUM_REQ).
//   req  in  NUM_REQ   request vector
//   ptr  in  IDX_W     index holding highest priority
//   idx  out IDX_W     winning index (0 when no request)
//   any  out 1         at least one request asserted
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int               pos;
    logic [IDX_W-1:0] cand;

    // Scan from the lowest priority offset upwards so that the offset closest
    // to ptr is the last assignment and therefore wins.
    always_comb begin
        idx  = '0;
        any  = |req;
        pos  = 0;
        cand = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            cand = IDX_W'(pos);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
// Shares the single write port of the async FIFO among NUM_REQ producers in the
// write-clock domain. Round-robin grants, each held for at most BURST_MAX
// accepted beats; a one-cycle arbitration bubble separates grants. The FIFO is
// never written while full.
//   clk        in   1                   write-domain clock (FIFO wr_clk)
//   rst        in   1                   asynchronous, active-low reset
//   req_valid  in   NUM_REQ             per-requester beat available
//   req_data   in   NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  NUM_REQ             beat of requester i accepted (one-hot or 0)
//   wr_en      out  1                   FIFO write enable
//   wdata      out  DATA_WIDTH          FIFO write data
//   full       in   1                   FIFO full
//   overflow   in   1                   FIFO overflow indication
//   ovf_clr    in   1                   clears ovf_err
//   owner      out  $clog2(NUM_REQ)     current grant index (valid when busy)
//   busy       out  1                   a grant is held
//   ovf_err    out  1                   sticky overflow flag
//   wr_count   out  CNT_W               accepted beats since reset, wraps
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = BURST_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         wdata,
    input  logic                          full,
    input  logic                          overflow,
    input  logic                          ovf_clr,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy,
    output logic                          ovf_err,
    output logic [CNT_W-1:0]              wr_count
);

    localparam int OWN_W  = $clog2(NUM_REQ);
    localparam int BEAT_W = $clog2(BURST_MAX + 1);

    localparam logic [0:0] ST_IDLE  = ARB_IDLE;
    localparam logic [0:0] ST_BURST = ARB_BURST;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_MAX - 1);

    logic [0:0]        state;
    logic [OWN_W-1:0]  rr_ptr;
    logic [OWN_W-1:0]  owner_q;
    logic [BEAT_W-1:0] beat_cnt;

    logic [OWN_W-1:0]  pick_idx;
    logic              pick_any;
    logic [OWN_W-1:0]  next_owner;
    logic              accept;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Priority rotates to the slot after the owner whether the burst ran to
    // BURST_MAX or was abandoned, so a releasing owner cannot immediately re-win
    // while others wait.
    assign next_owner = OWN_W'(wrap_inc(int'(owner_q), NUM_REQ));

    assign accept = (state == ST_BURST) && req_valid[owner_q] && !full;
    assign busy   = (state == ST_BURST);
    assign owner  = owner_q;
    assign wr_en  = accept;

    // Write mux is purely combinational off registered state so that full can
    // suppress the write in the very cycle it is asserted.
    always_comb begin
        wdata     = '0;
        req_ready = '0;
        if (accept) begin
            req_ready[owner_q] = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == OWN_W'(i)) begin
                    wdata = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            owner_q  <= '0;
            beat_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (pick_any) begin
                owner_q  <= pick_idx;
                beat_cnt <= '0;
                state    <= ST_BURST;
            end
        end else begin
            if (accept) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == LAST_BEAT) begin
                    state  <= ST_IDLE;
                    rr_ptr <= next_owner;
                end
            end else if (!req_valid[owner_q]) begin
                state  <= ST_IDLE;
                rr_ptr <= next_owner;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_count <= '0;
        end else if (accept) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    // Set has priority over clear so an overflow coinciding with ovf_clr is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if (overflow) begin
            ovf_err <= 1'b1;
        end else if (ovf_clr) begin
            ovf_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, BURST_MAX=4).
// Producers present data {id, seq} and advance seq when a beat is taken.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            wr_en;
    logic [DW-1:0]   wdata;
    logic            full;
    logic            overflow;
    logic            ovf_clr;
    logic [1:0]      owner;
    logic            busy;
    logic            ovf_err;
    logic [CW-1:0]   wr_count;

    fifo_wr_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .BURST_MAX  (BM),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wdata     (wdata),
        .full      (full),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .owner     (owner),
        .busy      (busy),
        .ovf_err   (ovf_err),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who holds the grant, how many beats it has had, where
    // the rotation starts next, and the expected counters.
    bit m_busy;
    int m_owner;
    int m_beats;
    int m_ptr;
    int m_count;
    bit m_ovf;
    int seq [N];

    logic          exp_wr_en;
    logic [DW-1:0] exp_wdata;
    logic [N-1:0]  exp_ready;

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_beats = 0;
        m_ptr   = 0;
        m_count = 0;
        m_ovf   = 1'b0;
    endtask

    // Apply inputs after the falling edge and compute expected combinational outputs.
    task automatic drive(input logic [N-1:0] rv, input logic f, input logic ov, input logic clr);
        @(negedge clk);
        req_valid = rv;
        full      = f;
        overflow  = ov;
        ovf_clr   = clr;
        for (int i = 0; i < N; i++) begin
            req_data[i*DW +: DW] = 8'(i * 64 + seq[i] % 64);
        end
        #1;
        exp_wr_en = rst && m_busy && req_valid[m_owner] && !full;
        exp_wdata = exp_wr_en ? req_data[m_owner*DW +: DW] : '0;
        exp_ready = exp_wr_en ? 4'(1 << m_owner) : '0;
    endtask

    // Advance the model across the rising edge.
    task automatic advance();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (!m_busy) begin
                if (req_valid != '0) begin
                    for (int k = 0; k < N; k++) begin
                        int c = (m_ptr + k) % N;
                        if (req_valid[c]) begin
                            m_owner = c;
                            break;
                        end
                    end
                    m_beats = 0;
                    m_busy  = 1'b1;
                end
            end else if (exp_wr_en) begin
                seq[m_owner] = seq[m_owner] + 1;
                m_beats = m_beats + 1;
                m_count = (m_count + 1) % (1 << CW);
                if (m_beats == BM) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_owner + 1) % N;
                end
            end else if (!req_valid[m_owner]) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end
            if (overflow) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            drive(4'hF, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== 1'b0 || req_ready !== 4'b0 || wr_count !== 16'd0 || busy !== 1'b0 ||
                ovf_err !== 1'b0 || wdata !== 8'd0) begin
                n_fail++;
                $display("FAIL reset: wr_en=%b req_ready=%b wr_count=%0d busy=%b ovf_err=%b wdata=%h, required all zero",
                         wr_en, req_ready, wr_count, busy, ovf_err, wdata);
            end
            if (i == 3) rst = 1'b1;
            advance();
        end
    endtask

    task automatic test_rotation();
        logic [1:0]    got_owner [$];
        logic [DW-1:0] got_data  [$];
        for (int cyc = 0; cyc < 20; cyc++) begin
            drive(4'hF, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                (m_busy && owner !== 2'(m_owner)) || wr_count !== CW'(m_count) || ovf_err !== m_ovf) begin
                n_fail++;
                $display("FAIL rotation cyc %0d: wr_en=%b wdata=%h ready=%b busy=%b owner=%0d cnt=%0d, expected %b %h %b %b %0d %0d",
                         cyc, wr_en, wdata, req_ready, busy, owner, wr_count, exp_wr_en, exp_wdata, exp_ready, m_busy, m_owner, m_count);
            end
            if (wr_en === 1'b1) begin
                got_owner.push_back(owner);
                got_data.push_back(wdata);
            end
            advance();
        end
        n_checks++;
        if (got_owner.size() != 16) begin
            n_fail++;
            $display("FAIL rotation beats: got %0d writes, required 16", got_owner.size());
        end
        for (int j = 0; j < got_owner.size() && j < 16; j++) begin
            n_checks++;
            if (got_owner[j] !== 2'(j / 4) || got_data[j][7:6] !== 2'(j / 4)) begin
                n_fail++;
                $display("FAIL rotation order beat %0d: owner=%0d data_id=%0d, required %0d", j, got_owner[j], got_data[j][7:6], j / 4);
            end
        end
        drive(4'hF, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd0 || wr_count !== 16'd16) begin
            n_fail++;
            $display("FAIL rotation wrap: busy=%b owner=%0d wr_count=%0d, required 1 0 16", busy, owner, wr_count);
        end
        advance();
    endtask

    task automatic test_full_stall();
        logic [DW-1:0] got [$];
        int s0;
        int g;
        s0 = -1;
        g  = 0;
        while (!(m_busy && m_owner == 1 && m_beats == 2) && g < 12) begin
            drive(4'b0010, 1'b0, 1'b0, 1'b0);
            if (m_busy && m_owner == 1 && s0 < 0) s0 = seq[1];
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                (m_busy && owner !== 2'(m_owner)) || wr_count !== CW'(m_count)) begin
                n_fail++;
                $display("FAIL stall lead-in: wr_en=%b wdata=%h ready=%b busy=%b owner=%0d cnt=%0d, expected %b %h %b %b %0d %0d",
                         wr_en, wdata, req_ready, busy, owner, wr_count, exp_wr_en, exp_wdata, exp_ready, m_busy, m_owner, m_count);
            end
            if (wr_en === 1'b1 && req_ready[1] === 1'b1) got.push_back(wdata);
            advance();
            g++;
        end
        n_checks++;
        if (!(m_busy && m_owner == 1 && m_beats == 2)) begin
            n_fail++;
            $display("FAIL stall setup: timeout reaching owner 1 beat 2, got busy=%b owner=%0d", busy, owner);
        end
        for (int i = 0; i < 5; i++) begin
            drive(4'b0010, 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== 1'b0 || req_ready !== 4'b0 || owner !== 2'd1 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stall hold %0d: wr_en=%b ready=%b owner=%0d busy=%b, required 0 0000 1 1", i, wr_en, req_ready, owner, busy);
            end
            advance();
        end
        g = 0;
        while (m_busy && g < 12) begin
            drive(4'b0010, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                wr_count !== CW'(m_count)) begin
                n_fail++;
                $display("FAIL stall drain: wr_en=%b wdata=%h ready=%b busy=%b cnt=%0d, expected %b %h %b %b %0d",
                         wr_en, wdata, req_ready, busy, wr_count, exp_wr_en, exp_wdata, exp_ready, m_busy, m_count);
            end
            if (wr_en === 1'b1 && req_ready[1] === 1'b1) got.push_back(wdata);
            advance();
            g++;
        end
        n_checks++;
        if (got.size() != BM) begin
            n_fail++;
            $display("FAIL stall beats: owner 1 wrote %0d beats, required %0d", got.size(), BM);
        end
        for (int k = 0; k < got.size() && k < BM; k++) begin
            n_checks++;
            if (got[k] !== 8'(64 + (s0 + k) % 64)) begin
                n_fail++;
                $display("FAIL stall data %0d: got %h, required %h", k, got[k], 8'(64 + (s0 + k) % 64));
            end
        end
    endtask

    task automatic test_early_release();
        int g;
        g = 0;
        while (!(m_busy && m_owner == 2 && m_beats == 2) && g < 12) begin
            drive(4'b1100, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                (m_busy && owner !== 2'(m_owner)) || wr_count !== CW'(m_count)) begin
                n_fail++;
                $display("FAIL release lead-in: wr_en=%b wdata=%h ready=%b busy=%b owner=%0d cnt=%0d, expected %b %h %b %b %0d %0d",
                         wr_en, wdata, req_ready, busy, owner, wr_count, exp_wr_en, exp_wdata, exp_ready, m_busy, m_owner, m_count);
            end
            advance();
            g++;
        end
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b1 || owner !== 2'd2) begin
            n_fail++;
            $display("FAIL release drop: wr_en=%b busy=%b owner=%0d, required 0 1 2", wr_en, busy, owner);
        end
        advance();
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL release bubble: wr_en=%b busy=%b, required 0 0", wr_en, busy);
        end
        advance();
        drive(4'b1000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd3 || wr_en !== 1'b1 || req_ready !== 4'b1000 || wdata[7:6] !== 2'd3) begin
            n_fail++;
            $display("FAIL release next: busy=%b owner=%0d wr_en=%b ready=%b wdata=%h, required 1 3 1 1000 id 3",
                     busy, owner, wr_en, req_ready, wdata);
        end
        advance();
    endtask

    task automatic test_overflow();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf set: ovf_err=%b, required 1", ovf_err);
        end
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf sticky: ovf_err=%b, required 1", ovf_err);
        end
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_err !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf clear: ovf_err=%b, required 0", ovf_err);
        end
        advance();
        drive(4'b0000, 1'b0, 1'b1, 1'b1);
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (ovf_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf set-wins: ovf_err=%b, required 1", ovf_err);
        end
        advance();
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        advance();
    endtask

    task automatic test_mid_burst_reset();
        int g;
        g = 0;
        while (!(m_busy && m_owner == 0 && m_beats == 2) && g < 12) begin
            drive(4'b0001, 1'b0, 1'b0, 1'b0);
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                (m_busy && owner !== 2'(m_owner)) || wr_count !== CW'(m_count) || ovf_err !== m_ovf) begin
                n_fail++;
                $display("FAIL midreset lead-in: wr_en=%b wdata=%h ready=%b busy=%b owner=%0d cnt=%0d ovf=%b, expected %b %h %b %b %0d %0d %b",
                         wr_en, wdata, req_ready, busy, owner, wr_count, ovf_err, exp_wr_en, exp_wdata, exp_ready, m_busy, m_owner, m_count, m_ovf);
            end
            advance();
            g++;
        end
        drive(4'b0001, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (wr_en !== 1'b1 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset beat2: wr_en=%b owner=%0d, required 1 0", wr_en, owner);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (wr_en !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || wdata !== 8'd0 || wr_count !== 16'd0 || owner !== 2'd0) begin
            n_fail++;
            $display("FAIL midreset async: wr_en=%b ready=%b busy=%b wdata=%h wr_count=%0d owner=%0d, required all zero",
                     wr_en, req_ready, busy, wdata, wr_count, owner);
        end
        model_reset();
        advance();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        advance();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || owner !== 2'd1 || wr_en !== 1'b1 || wr_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midreset regrant: busy=%b owner=%0d wr_en=%b wr_count=%0d, required 1 1 1 0", busy, owner, wr_en, wr_count);
        end
        advance();
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (wr_count !== 16'd1) begin
            n_fail++;
            $display("FAIL midreset count: wr_count=%0d, required 1", wr_count);
        end
        advance();
    endtask

    task automatic test_random();
        logic [N-1:0] rv;
        logic         f;
        logic         ov;
        logic         clr;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rv  = 4'($urandom_range(0, 15));
            f   = ($urandom_range(0, 3) == 0);
            ov  = ($urandom_range(0, 31) == 0);
            clr = ($urandom_range(0, 7) == 0);
            drive(rv, f, ov, clr);
            n_checks++;
            if (wr_en !== exp_wr_en || wdata !== exp_wdata || req_ready !== exp_ready || busy !== m_busy ||
                (m_busy && owner !== 2'(m_owner)) || wr_count !== CW'(m_count) || ovf_err !== m_ovf) begin
                n_fail++;
                $display("FAIL random cyc %0d: wr_en=%b wdata=%h ready=%b busy=%b owner=%0d cnt=%0d ovf=%b, expected %b %h %b %b %0d %0d %b",
                         cyc, wr_en, wdata, req_ready, busy, owner, wr_count, ovf_err, exp_wr_en, exp_wdata, exp_ready, m_busy, m_owner, m_count, m_ovf);
            end
            advance();
        end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = 4'hF;
        req_data  = '0;
        full      = 1'b0;
        overflow  = 1'b0;
        ovf_clr   = 1'b0;
        for (int i = 0; i < N; i++) seq[i] = 0;
        model_reset();
        test_reset();
        test_rotation();
        test_full_stall();
        test_early_release();
        test_overflow();
        test_mid_burst_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
